// File: rtl/uart_cmd_rx.sv
// Frame receiver above the UART byte receiver: sync, cmd, data_hi, data_lo, checksum -> 24-bit command.
// Result is registered one cycle after the checksum byte. Every byte is consumed; a frame arriving while cmd_rdy is pending is dropped.
module uart_cmd_rx #(
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 52080
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_rdy,
  input  logic [7:0]  rx_data,
  output logic        clr_rdy,
  output logic [7:0]  cmd,
  output logic [15:0] data,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  output logic        frm_err,
  output logic [7:0]  err_cnt
);

  typedef enum logic [2:0] {
    HUNT = 3'd0,
    CMD  = 3'd1,
    DHI  = 3'd2,
    DLO  = 3'd3,
    CHK  = 3'd4
  } state_t;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      state, state_nxt;
  logic [15:0] tmo_cnt;
  logic [7:0]  cmd_hold, hi_hold, lo_hold;
  logic [7:0]  sum8;
  logic        tmo_hit;
  logic        cap_cmd, cap_hi, cap_lo;
  logic        chk_byte, overrun, accept, err_evt;

  // An arriving byte beats an expiring timer in the same cycle.
  assign tmo_hit = (state != HUNT) && !rx_rdy && (tmo_cnt == TMO_LAST);
  assign sum8    = cmd_hold + hi_hold + lo_hold + rx_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= HUNT;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      HUNT: if (rx_rdy && rx_data == SYNC_BYTE) state_nxt = CMD;
      CMD: begin
        if (rx_rdy)       state_nxt = DHI;
        else if (tmo_hit) state_nxt = HUNT;
      end
      DHI: begin
        if (rx_rdy)       state_nxt = DLO;
        else if (tmo_hit) state_nxt = HUNT;
      end
      DLO: begin
        if (rx_rdy)       state_nxt = CHK;
        else if (tmo_hit) state_nxt = HUNT;
      end
      CHK: if (rx_rdy || tmo_hit) state_nxt = HUNT;
      default: state_nxt = HUNT;
    endcase
  end

  always_comb begin
    clr_rdy  = rx_rdy;
    cap_cmd  = 1'b0;
    cap_hi   = 1'b0;
    cap_lo   = 1'b0;
    chk_byte = 1'b0;
    case (state)
      CMD:     cap_cmd  = rx_rdy;
      DHI:     cap_hi   = rx_rdy;
      DLO:     cap_lo   = rx_rdy;
      CHK:     chk_byte = rx_rdy;
      default: ;
    endcase
    overrun = chk_byte && cmd_rdy && !clr_cmd_rdy;
    accept  = chk_byte && (sum8 == 8'h00) && !overrun;
    err_evt = tmo_hit || (chk_byte && ((sum8 != 8'h00) || overrun));
  end

  always_ff @(posedge clk) begin
    if (cap_cmd) cmd_hold <= rx_data;
    if (cap_hi)  hi_hold  <= rx_data;
    if (cap_lo)  lo_hold  <= rx_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      tmo_cnt <= 16'd0;
    else if (state == HUNT || rx_rdy || tmo_hit)
      tmo_cnt <= 16'd0;
    else
      tmo_cnt <= tmo_cnt + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd     <= 8'h00;
      data    <= 16'h0000;
      cmd_rdy <= 1'b0;
      frm_err <= 1'b0;
      err_cnt <= 8'h00;
    end else begin
      frm_err <= err_evt;
      if (accept) begin
        cmd     <= cmd_hold;
        data    <= {hi_hold, lo_hold};
        cmd_rdy <= 1'b1;
      end else if (clr_cmd_rdy) begin
        cmd_rdy <= 1'b0;
      end
      if (err_evt && err_cnt != 8'hFF)
        err_cnt <= err_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_uart_cmd_rx.sv
// Directed bench for uart_cmd_rx with a short timeout so gaps stay small.
module tb_uart_cmd_rx;
  localparam int TMO = 100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_rdy = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        clr_cmd_rdy = 1'b0;
  logic        clr_rdy;
  logic [7:0]  cmd;
  logic [15:0] data;
  logic        cmd_rdy;
  logic        frm_err;
  logic [7:0]  err_cnt;

  int total = 0;
  int bad = 0;
  int clr_seen = 0;

  uart_cmd_rx #(.SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .rx_rdy(rx_rdy), .rx_data(rx_data),
    .clr_rdy(clr_rdy), .cmd(cmd), .data(data), .cmd_rdy(cmd_rdy),
    .clr_cmd_rdy(clr_cmd_rdy), .frm_err(frm_err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (clr_rdy) clr_seen <= clr_seen + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // Byte presented for exactly one cycle after 'gap' idle cycles; returns 1ns after the accepting edge.
  task automatic send_byte(input logic [7:0] b, input int gap, input logic clr);
    repeat (gap) @(posedge clk);
    @(posedge clk); #1;
    rx_rdy = 1'b1; rx_data = b; clr_cmd_rdy = clr;
    @(posedge clk); #1;
    rx_rdy = 1'b0; clr_cmd_rdy = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] c, input logic [7:0] h, input logic [7:0] l,
                            input logic [7:0] s, input int gap, input logic clr_on_chk);
    send_byte(8'hA5, gap, 1'b0);
    send_byte(c, gap, 1'b0);
    send_byte(h, gap, 1'b0);
    send_byte(l, gap, 1'b0);
    send_byte(s, gap, clr_on_chk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rx_rdy = 1'b1; #3;
    total++; if (cmd !== 8'h00)     begin bad++; $display("FAIL rst_cmd got=%h exp=00", cmd); end
    total++; if (data !== 16'h0000) begin bad++; $display("FAIL rst_data got=%h exp=0000", data); end
    total++; if (cmd_rdy !== 1'b0)  begin bad++; $display("FAIL rst_cmd_rdy got=%b exp=0", cmd_rdy); end
    total++; if (frm_err !== 1'b0)  begin bad++; $display("FAIL rst_frm_err got=%b exp=0", frm_err); end
    total++; if (err_cnt !== 8'h00) begin bad++; $display("FAIL rst_err_cnt got=%h exp=00", err_cnt); end
    total++; if (clr_rdy !== 1'b1)  begin bad++; $display("FAIL rst_clr_rdy_follow got=%b exp=1", clr_rdy); end
    rx_rdy = 1'b0; #1;
    total++; if (clr_rdy !== 1'b0)  begin bad++; $display("FAIL rst_clr_rdy_idle got=%b exp=0", clr_rdy); end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int base;
    do_reset();
    base = clr_seen;
    send_frame(8'h12, 8'h34, 8'h56, 8'h64, 50, 1'b0);
    total++; if (clr_seen - base != 5) begin bad++; $display("FAIL basic_clr_pulses got=%0d exp=5", clr_seen - base); end
    total++; if (cmd !== 8'h12)      begin bad++; $display("FAIL basic_cmd got=%h exp=12", cmd); end
    total++; if (data !== 16'h3456)  begin bad++; $display("FAIL basic_data got=%h exp=3456", data); end
    total++; if (cmd_rdy !== 1'b1)   begin bad++; $display("FAIL basic_cmd_rdy got=%b exp=1", cmd_rdy); end
    total++; if (err_cnt !== 8'h00)  begin bad++; $display("FAIL basic_err_cnt got=%h exp=00", err_cnt); end
    total++; if (frm_err !== 1'b0)   begin bad++; $display("FAIL basic_frm_err got=%b exp=0", frm_err); end
    @(posedge clk); #1; clr_cmd_rdy = 1'b1;
    @(posedge clk); #1; clr_cmd_rdy = 1'b0;
    total++; if (cmd_rdy !== 1'b0)   begin bad++; $display("FAIL basic_clear got=%b exp=0", cmd_rdy); end
    total++; if (cmd !== 8'h12)      begin bad++; $display("FAIL basic_cmd_hold got=%h exp=12", cmd); end
  endtask

  task automatic test_gap_boundary();
    do_reset();
    // each byte lands in the very cycle the timer reaches its last count
    send_frame(8'h12, 8'h34, 8'h56, 8'h64, TMO - 2, 1'b0);
    total++; if (cmd_rdy !== 1'b1)   begin bad++; $display("FAIL edge_cmd_rdy got=%b exp=1", cmd_rdy); end
    total++; if (err_cnt !== 8'h00)  begin bad++; $display("FAIL edge_err_cnt got=%h exp=00", err_cnt); end
    total++; if (data !== 16'h3456)  begin bad++; $display("FAIL edge_data got=%h exp=3456", data); end
  endtask

  task automatic test_hunt();
    do_reset();
    send_byte(8'h00, 0, 1'b0);
    send_byte(8'hFF, 0, 1'b0);
    total++; if (frm_err !== 1'b0)   begin bad++; $display("FAIL hunt_frm_err got=%b exp=0", frm_err); end
    send_frame(8'h01, 8'h00, 8'h00, 8'hFF, 0, 1'b0);
    total++; if (cmd !== 8'h01)      begin bad++; $display("FAIL hunt_cmd got=%h exp=01", cmd); end
    total++; if (data !== 16'h0000)  begin bad++; $display("FAIL hunt_data got=%h exp=0000", data); end
    total++; if (cmd_rdy !== 1'b1)   begin bad++; $display("FAIL hunt_cmd_rdy got=%b exp=1", cmd_rdy); end
    total++; if (err_cnt !== 8'h00)  begin bad++; $display("FAIL hunt_err_cnt got=%h exp=00", err_cnt); end
  endtask

  task automatic test_checksum();
    do_reset();
    send_frame(8'h12, 8'h34, 8'h56, 8'h65, 0, 1'b0);
    total++; if (frm_err !== 1'b1)   begin bad++; $display("FAIL cks_frm_err got=%b exp=1", frm_err); end
    total++; if (err_cnt !== 8'h01)  begin bad++; $display("FAIL cks_err_cnt got=%h exp=01", err_cnt); end
    total++; if (cmd_rdy !== 1'b0)   begin bad++; $display("FAIL cks_cmd_rdy got=%b exp=0", cmd_rdy); end
    total++; if (cmd !== 8'h00)      begin bad++; $display("FAIL cks_cmd got=%h exp=00", cmd); end
    @(posedge clk); #1;
    total++; if (frm_err !== 1'b0)   begin bad++; $display("FAIL cks_pulse_width got=%b exp=0", frm_err); end
    send_frame(8'h12, 8'h34, 8'h56, 8'h64, 0, 1'b0);
    total++; if (cmd_rdy !== 1'b1)   begin bad++; $display("FAIL cks_next_frame got=%b exp=1", cmd_rdy); end
  endtask

  task automatic test_timeout();
    do_reset();
    send_byte(8'hA5, 0, 1'b0);
    send_byte(8'h12, 0, 1'b0);
    repeat (TMO - 1) @(posedge clk);
    #1;
    total++; if (frm_err !== 1'b0)   begin bad++; $display("FAIL tmo_early got=%b exp=0", frm_err); end
    @(posedge clk); #1;
    total++; if (frm_err !== 1'b1)   begin bad++; $display("FAIL tmo_frm_err got=%b exp=1", frm_err); end
    total++; if (err_cnt !== 8'h01)  begin bad++; $display("FAIL tmo_err_cnt got=%h exp=01", err_cnt); end
    @(posedge clk); #1;
    total++; if (frm_err !== 1'b0)   begin bad++; $display("FAIL tmo_pulse_width got=%b exp=0", frm_err); end
    send_frame(8'h12, 8'h34, 8'h56, 8'h64, 0, 1'b0);
    total++; if (cmd_rdy !== 1'b1)   begin bad++; $display("FAIL tmo_recover_rdy got=%b exp=1", cmd_rdy); end
    total++; if (data !== 16'h3456)  begin bad++; $display("FAIL tmo_recover_data got=%h exp=3456", data); end
    total++; if (err_cnt !== 8'h01)  begin bad++; $display("FAIL tmo_recover_cnt got=%h exp=01", err_cnt); end
  endtask

  task automatic test_overrun();
    do_reset();
    send_frame(8'h12, 8'h34, 8'h56, 8'h64, 0, 1'b0);
    send_frame(8'h01, 8'h00, 8'h00, 8'hFF, 0, 1'b0);
    total++; if (cmd !== 8'h12)      begin bad++; $display("FAIL ovr_cmd got=%h exp=12", cmd); end
    total++; if (data !== 16'h3456)  begin bad++; $display("FAIL ovr_data got=%h exp=3456", data); end
    total++; if (err_cnt !== 8'h01)  begin bad++; $display("FAIL ovr_err_cnt got=%h exp=01", err_cnt); end
    total++; if (frm_err !== 1'b1)   begin bad++; $display("FAIL ovr_frm_err got=%b exp=1", frm_err); end
    send_frame(8'h01, 8'h00, 8'h00, 8'hFF, 0, 1'b1);
    total++; if (cmd !== 8'h01)      begin bad++; $display("FAIL ovr_clr_cmd got=%h exp=01", cmd); end
    total++; if (data !== 16'h0000)  begin bad++; $display("FAIL ovr_clr_data got=%h exp=0000", data); end
    total++; if (cmd_rdy !== 1'b1)   begin bad++; $display("FAIL ovr_clr_rdy got=%b exp=1", cmd_rdy); end
    total++; if (err_cnt !== 8'h01)  begin bad++; $display("FAIL ovr_clr_cnt got=%h exp=01", err_cnt); end
    total++; if (frm_err !== 1'b0)   begin bad++; $display("FAIL ovr_clr_frm_err got=%b exp=0", frm_err); end
  endtask

  task automatic test_saturate_and_reset();
    do_reset();
    for (int i = 0; i < 254; i++) send_frame(8'h12, 8'h34, 8'h56, 8'h65, 0, 1'b0);
    total++; if (err_cnt !== 8'd254) begin bad++; $display("FAIL sat_254 got=%0d exp=254", err_cnt); end
    send_frame(8'h12, 8'h34, 8'h56, 8'h65, 0, 1'b0);
    total++; if (err_cnt !== 8'd255) begin bad++; $display("FAIL sat_255 got=%0d exp=255", err_cnt); end
    for (int i = 0; i < 5; i++) send_frame(8'h12, 8'h34, 8'h56, 8'h65, 0, 1'b0);
    total++; if (err_cnt !== 8'd255) begin bad++; $display("FAIL sat_hold got=%0d exp=255", err_cnt); end
    send_frame(8'h12, 8'h34, 8'h56, 8'h64, 0, 1'b0);
    send_byte(8'hA5, 0, 1'b0);
    send_byte(8'h77, 0, 1'b0);
    #2; rst_n = 1'b0; #1;
    total++; if (cmd !== 8'h00)      begin bad++; $display("FAIL mid_rst_cmd got=%h exp=00", cmd); end
    total++; if (data !== 16'h0000)  begin bad++; $display("FAIL mid_rst_data got=%h exp=0000", data); end
    total++; if (cmd_rdy !== 1'b0)   begin bad++; $display("FAIL mid_rst_cmd_rdy got=%b exp=0", cmd_rdy); end
    total++; if (err_cnt !== 8'h00)  begin bad++; $display("FAIL mid_rst_err_cnt got=%h exp=00", err_cnt); end
    @(posedge clk); #1; rst_n = 1'b1;
    send_frame(8'h01, 8'h00, 8'h00, 8'hFF, 0, 1'b0);
    total++; if (cmd !== 8'h01)      begin bad++; $display("FAIL post_rst_cmd got=%h exp=01", cmd); end
    total++; if (cmd_rdy !== 1'b1)   begin bad++; $display("FAIL post_rst_cmd_rdy got=%b exp=1", cmd_rdy); end
    total++; if (err_cnt !== 8'h00)  begin bad++; $display("FAIL post_rst_err_cnt got=%h exp=00", err_cnt); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gap_boundary();
    test_hunt();
    test_checksum();
    test_timeout();
    test_overrun();
    test_saturate_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
